fpu_mult_scheduler: RTL and testbench

Round-robin scheduler that shares one IEEE-754 single-precision multiplier among `NUM_REQ` requesters in the CNN datapath. It accepts one operand pair at a time and drives the multiplier's start/operand inputs. It waits for the multiplier's ready, with a timeout guard, and returns the product and exponent-overflow flags to the granted requester. Requesters are typically convolution MAC lanes.

---
 rtl/fpu_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/fpu_mult_scheduler.sv | 100 ++++++++++
 tb/tb_fpu_mult_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FP32 multiplier scheduler.
package fpu_sched_pkg;

  localparam int OP_W   = 32;
  localparam int FLAG_W = 3;
  localparam logic [OP_W-1:0] QNAN_F32 = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [OP_W-1:0]   result;
    logic [FLAG_W-1:0] flags;
    logic              timeout;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority encoder: first set request strictly after last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         gnt_oh,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx     = 0;
    gnt_idx = '0;
    for (int o = NUM_REQ; o >= 1; o--) begin
      idx = (int'(last_grant) + o) % NUM_REQ;
      if (req[idx]) gnt_idx = IDX_W'(idx);
    end
    gnt_any = |req;
    gnt_oh  = NUM_REQ'(gnt_any) << gnt_idx;
  end

endmodule

// File: rtl/fpu_mult_scheduler.sv
// Round-robin sharing of one FP32 multiplier among NUM_REQ requesters,
// with a timeout guard and a drain state that waits out stale ready.
module fpu_mult_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [OP_W-1:0]         rsp_result,
  output logic [FLAG_W-1:0]       rsp_flags,
  output logic                    rsp_timeout,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  output logic                    mul_start,
  input  logic [OP_W-1:0]         mul_result,
  input  logic [FLAG_W-1:0]       mul_flags,
  input  logic                    mul_ready
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  sched_state_t                   state;
  logic [IDX_W-1:0]               grant, last_grant;
  logic [CNT_W-1:0]               cnt;
  rsp_t                           rsp_q;
  logic [NUM_REQ-1:0][OP_W-1:0]   a_vec, b_vec;
  logic [NUM_REQ-1:0]             gnt_oh;
  logic [IDX_W-1:0]               gnt_idx;
  logic                           gnt_any;

  assign a_vec = req_a;
  assign b_vec = req_b;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt_oh     (gnt_oh),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign req_ready   = (state == ST_IDLE) ? gnt_oh : '0;
  assign rsp_result  = rsp_q.result;
  assign rsp_flags   = rsp_q.flags;
  assign rsp_timeout = rsp_q.timeout;

  // Reset lands in DRAIN so a ready left over from an abandoned op is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_DRAIN;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_start  <= 1'b0;
      rsp_valid  <= '0;
      rsp_q      <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        ST_IDLE: if (gnt_any) begin
          mul_a      <= a_vec[gnt_idx];
          mul_b      <= b_vec[gnt_idx];
          grant      <= gnt_idx;
          last_grant <= gnt_idx;
          cnt        <= '0;
          mul_start  <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_ready) begin
            rsp_q     <= '{result: mul_result, flags: mul_flags, timeout: 1'b0};
            rsp_valid <= NUM_REQ'(1) << grant;
            mul_start <= 1'b0;
            state     <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_q     <= '{result: QNAN_F32, flags: '0, timeout: 1'b1};
            rsp_valid <= NUM_REQ'(1) << grant;
            mul_start <= 1'b0;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP:  state <= ST_DRAIN;
        ST_DRAIN: if (!mul_ready) state <= ST_IDLE;
        default:  state <= ST_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mult_scheduler.sv
// Randomized bench for fpu_mult_scheduler with a behavioural multiplier and grant model.
module tb_fpu_mult_scheduler;
  localparam int N       = 4;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     rsp_result, mul_a, mul_b, mul_result;
  logic [2:0]      rsp_flags, mul_flags;
  logic            rsp_timeout, mul_start, mul_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int lg      = N - 1;

  fpu_mult_scheduler #(.NUM_REQ(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_result(mul_result), .mul_flags(mul_flags),
    .mul_ready(mul_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next grant: first valid requester after the previous winner, wrapping.
  function automatic int exp_grant(input logic [N-1:0] m);
    for (int o = 1; o <= N; o++)
      if (m[(lg + o) % N]) return (lg + o) % N;
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = $urandom;
      req_b[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_flags"}, rsp_flags, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_mul_ab"}, {mul_a, mul_b}, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
  endtask

  // One complete operation; called just after a negedge, returns at a negedge.
  task automatic run_op(input logic [N-1:0] mask, input bit keep, input int lat,
                        input int hold, input bit never, input logic [2:0] flg,
                        input logic [31:0] res, output int obs_g);
    int g, n;
    bit got, rr_bad, st_bad;
    logic [31:0] ea, eb, er;
    logic [2:0]  ef;
    obs_g = -1;
    g = exp_grant(mask);
    req_valid = mask;
    #1;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (req_ready != 0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", got, 1);
    if (!got) return;
    for (int i = 0; i < N; i++) if (req_ready[i]) obs_g = i;
    chk("grant_onehot", req_ready, 64'(1) << g);
    ea = req_a[g*32 +: 32];
    eb = req_b[g*32 +: 32];
    lg = g;
    @(posedge clk); #1;
    if (!keep) req_valid = '0;
    @(negedge clk);
    chk("start", mul_start, 1);
    chk("mul_ab", {mul_a, mul_b}, {ea, eb});
    rr_bad = (req_ready != 0);
    st_bad = 1'b0;
    if (!never) begin
      for (int c = 1; c < lat; c++) begin
        @(negedge clk);
        rr_bad |= (req_ready != 0);
        st_bad |= (mul_start != 1'b1) || (rsp_valid != 0);
      end
      mul_ready = 1'b1; mul_result = res; mul_flags = flg;
      @(negedge clk);
      er = res; ef = flg;
    end else begin
      n = 1;
      while (rsp_valid == 0 && n < 4 * TIMEOUT) begin
        @(negedge clk);
        n++;
        rr_bad |= (req_ready != 0);
        if (rsp_valid == 0) st_bad |= (mul_start != 1'b1);
      end
      chk("timeout_latency", n, TIMEOUT + 1);
      er = 32'h7FC0_0000; ef = 3'b000;
    end
    chk("wait_start_held", st_bad, 0);
    chk("rsp_valid", rsp_valid, 64'(1) << g);
    chk("rsp_result", rsp_result, er);
    chk("rsp_flags", rsp_flags, ef);
    chk("rsp_timeout", rsp_timeout, never);
    chk("start_low_resp", mul_start, 0);
    rr_bad |= (req_ready != 0);
    for (int c = 1; c < hold && !never; c++) begin
      @(negedge clk);
      rr_bad |= (req_ready != 0) || (rsp_valid != 0);
    end
    mul_ready = 1'b0;
    chk("no_ready_outside_idle", rr_bad, 0);
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("rsp_hold", {rsp_result, rsp_flags}, {er, ef});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int g;
    int seq [5] = '{0, 1, 2, 3, 0};
    bit bad;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    mul_result = '0; mul_flags = '0; mul_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_chk("reset");
    rst_n = 1'b1;

    // Contention: everyone asks, grants rotate from requester 0.
    for (int i = 0; i < 5; i++) begin
      rand_data();
      run_op(4'b1111, 1'b1, $urandom_range(1, 4), 1, 1'b0, 3'($urandom), $urandom, g);
      chk("contention_order", g, seq[i]);
    end

    rand_data();
    req_a[31:0] = 32'h4040_0000; req_b[31:0] = 32'h4000_0000;
    run_op(4'b0001, 1'b0, 5, 1, 1'b0, 3'b000, 32'h40C0_0000, g);
    chk("single_grant", g, 0);

    rand_data();
    run_op(4'b0100, 1'b0, 3, 1, 1'b0, 3'b101, $urandom, g);

    rand_data();
    run_op(4'b0010, 1'b0, 0, 1, 1'b1, 3'b000, 32'h0, g);

    // Stale ready held for 3 cycles with requests still pending.
    rand_data();
    run_op(4'b1001, 1'b1, 2, 3, 1'b0, 3'b010, $urandom, g);

    // Reset in the middle of WAIT.
    rand_data();
    req_valid = 4'b0100;
    #1;
    for (int c = 0; c < 40 && req_ready == 0; c++) @(negedge clk);
    chk("mw_accept", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("mw_in_wait", mul_start, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_chk("midwait");
    lg = N - 1;
    req_valid = 4'b1010; mul_ready = 1'b1; mul_result = $urandom;
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      bad |= (rsp_valid != 0) || (req_ready != 0);
    end
    chk("mw_dropped", bad, 0);
    mul_ready = 1'b0;
    rand_data();
    run_op(4'b1010, 1'b0, 2, 1, 1'b0, 3'b001, $urandom, g);
    chk("mw_first_grant", g, 1);

    for (int i = 0; i < 25; i++) begin
      rand_data();
      run_op(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(1, 6),
             $urandom_range(1, 3), ($urandom_range(0, 7) == 0), 3'($urandom), $urandom, g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
